// File: rtl/spi_reg_pkg.sv
// SPI register-access shared definitions: FSM state encoding and command-byte layout.
package spi_reg_pkg;

  localparam int CMD_W  = 8;
  localparam int WR_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_RD_LOAD = 3'd2,
    ST_DATA    = 3'd3,
    ST_HOLD    = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, followed by a one-flop
// rise/fall detector on the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the input and keep the previous synchronized level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_access.sv
// SPI (mode 0) slave giving register-bank access: 8-bit command (bit 7 = write,
// low bits = address) followed by one DATA_WIDTH data word, MSB first.
// Optional build macro: SPI_AUTO_INC_EN enables burst transfers with address
// auto-increment while cs_n stays low.
module spi_reg_access
  import spi_reg_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 16,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  spi_wr_en,
  output logic [ADDR_W-1:0]     spi_addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr_spi,
  output logic                  spi_rd_en,
  output logic [ADDR_W-1:0]     spi_addr_rd,
  input  logic [DATA_WIDTH-1:0] data_rd_spi,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2((DATA_WIDTH > CMD_W) ? DATA_WIDTH : CMD_W);

  logic w_sclk_lvl_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_sync;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (sclk),
    .o_sync  (w_sclk_lvl_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (cs_n),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (mosi),
    .o_sync  (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  spi_state_e              r_state;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [CMD_W-2:0]        r_cmd;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_is_wr;
  logic [DATA_WIDTH-2:0]   r_shift_in;
  logic [DATA_WIDTH-1:0]   r_shift_out;
  logic                    r_skip_fall;
  logic                    r_word_done;
  logic                    r_wr_en;
  logic [ADDR_W-1:0]       r_addr_wr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_frame_err;
  logic [1:0]              r_settle;
  logic                    r_armed;

  logic [CMD_W-1:0]        w_cmd_next;
  logic                    w_abort;

  assign w_cmd_next = {r_cmd, w_mosi};

  // A cs_n rise is an abort unless it lands in IDLE/HOLD or on a word boundary
  // of a burst that has already completed at least one word.
  assign w_abort = (r_state == ST_CMD) ||
                   (((r_state == ST_RD_LOAD) || (r_state == ST_DATA)) &&
                    !(r_word_done && (r_bit_cnt == '0)));

`ifdef SPI_AUTO_INC_EN
  logic [ADDR_W-1:0] w_addr_inc;
  assign w_addr_inc = (r_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_addr + ADDR_W'(1);
`endif

  // Frame sequencing, serial shifting and register strobes.
  // r_armed blocks the artificial cs_n falling edge seen when reset releases
  // while cs_n is already low: a frame may only start once cs_n has been
  // observed high after the synchronizer pipeline has settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_is_wr     <= 1'b0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_skip_fall <= 1'b0;
      r_word_done <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr_wr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_settle    <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_settle != 2'd3) begin
        r_settle <= r_settle + 2'd1;
      end else if (w_cs_sync) begin
        r_armed <= 1'b1;
      end
      if (w_cs_rise) begin
        r_frame_err <= w_abort;
        r_state     <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_cs_fall && r_armed) begin
              r_state     <= ST_CMD;
              r_bit_cnt   <= '0;
              r_word_done <= 1'b0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_cmd <= w_cmd_next[CMD_W-2:0];
              if (r_bit_cnt == CNT_W'(CMD_W - 1)) begin
                r_bit_cnt <= '0;
                r_addr    <= w_cmd_next[ADDR_W-1:0];
                r_is_wr   <= w_cmd_next[WR_BIT];
                r_state   <= w_cmd_next[WR_BIT] ? ST_DATA : ST_RD_LOAD;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_RD_LOAD: begin
            r_shift_out <= data_rd_spi;
            r_skip_fall <= 1'b1;
            r_state     <= ST_DATA;
          end
          ST_DATA: begin
            if (w_sclk_fall && !r_is_wr) begin
              if (r_skip_fall) begin
                r_skip_fall <= 1'b0;
              end else begin
                r_shift_out <= {r_shift_out[DATA_WIDTH-2:0], 1'b0};
              end
            end
            if (w_sclk_rise) begin
              r_shift_in <= {r_shift_in[DATA_WIDTH-3:0], w_mosi};
              if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                r_bit_cnt   <= '0;
                r_word_done <= 1'b1;
                if (r_is_wr) begin
                  r_wr_en   <= 1'b1;
                  r_addr_wr <= r_addr;
                  r_wr_data <= {r_shift_in, w_mosi};
                end
`ifdef SPI_AUTO_INC_EN
                r_addr  <= w_addr_inc;
                r_state <= r_is_wr ? ST_DATA : ST_RD_LOAD;
`else
                r_state <= ST_HOLD;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_HOLD: begin
            r_state <= ST_HOLD;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso        = ((r_state == ST_DATA) && !r_is_wr) ? r_shift_out[DATA_WIDTH-1] : 1'b0;
  assign miso_oe     = ~w_cs_sync;
  assign spi_wr_en   = r_wr_en;
  assign spi_addr_wr = r_addr_wr;
  assign data_wr_spi = r_wr_data;
  assign spi_rd_en   = (r_state == ST_RD_LOAD);
  assign spi_addr_rd = r_addr;
  assign busy        = (r_state != ST_IDLE);
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_reg_access.sv
// Self-checking bench for spi_reg_access: directed vector table, randomized
// frames against a register-bank reference model, and multi-cycle corner cases.
module tb_spi_reg_access;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sclk;
  logic          cs_n;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic          spi_wr_en;
  logic [AW-1:0] spi_addr_wr;
  logic [DW-1:0] data_wr_spi;
  logic          spi_rd_en;
  logic [AW-1:0] spi_addr_rd;
  logic [DW-1:0] data_rd_spi;
  logic          busy;
  logic          frame_err;

  always #5 clk = ~clk;

  spi_reg_access #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .spi_wr_en   (spi_wr_en),
    .spi_addr_wr (spi_addr_wr),
    .data_wr_spi (data_wr_spi),
    .spi_rd_en   (spi_rd_en),
    .spi_addr_rd (spi_addr_rd),
    .data_rd_spi (data_rd_spi),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  // Register bank the DUT talks to
  logic [DW-1:0] env_bank [NR];
  logic          preset_en = 1'b0;
  logic [AW-1:0] preset_addr = '0;
  logic [DW-1:0] preset_data = '0;

  always @(posedge clk) begin
    if (preset_en) env_bank[preset_addr] <= preset_data;
    else if (spi_wr_en) env_bank[spi_addr_wr] <= data_wr_spi;
  end
  assign data_rd_spi = env_bank[spi_addr_rd];

  // Strobe monitor
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [AW-1:0] rd_addr_q [$];
  int            err_cnt   = 0;
  logic          both_seen = 1'b0;

  always @(negedge clk) begin
    if (spi_wr_en) begin
      wr_addr_q.push_back(spi_addr_wr);
      wr_data_q.push_back(data_wr_spi);
    end
    if (spi_rd_en) rd_addr_q.push_back(spi_addr_rd);
    if (frame_err) err_cnt++;
    if (spi_wr_en && spi_rd_en) both_seen = 1'b1;
  end

  // Reference model of register contents
  logic [DW-1:0] model_bank [NR];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] wr_addr_at(input int idx);
    return (idx < wr_addr_q.size()) ? wr_addr_q[idx] : 'x;
  endfunction
  function automatic logic [DW-1:0] wr_data_at(input int idx);
    return (idx < wr_data_q.size()) ? wr_data_q[idx] : 'x;
  endfunction
  function automatic logic [AW-1:0] rd_addr_at(input int idx);
    return (idx < rd_addr_q.size()) ? rd_addr_q[idx] : 'x;
  endfunction

  task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    preset_en   = 1'b1;
    preset_addr = a;
    preset_data = d;
    @(negedge clk);
    preset_en   = 1'b0;
  endtask

  // Mode-0 master: sends the top nbits of {cmd, data}, samples miso just before each rise
  task automatic spi_xfer(input logic [7:0] cmd, input logic [63:0] data, input int nbits,
                          input logic leave_low, output logic [71:0] cap, output logic oe_seen);
    logic [71:0] stream;
    stream = {cmd, data};
    cap    = '0;
    @(negedge clk);
    cs_n = 1'b0;
    #100;
    oe_seen = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      mosi = stream[71-i];
      #50;
      cap  = {cap[70:0], miso};
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    #100;
    if (!leave_low) begin
      cs_n = 1'b1;
      #200;
    end
  endtask

  // Single-word frame checked against the reference model
  task automatic do_frame_model(input logic [7:0] cmd, input logic [DW-1:0] data, input string tag);
    logic [AW-1:0] a;
    logic [39:0]   exp_stream;
    logic [71:0]   cap;
    logic          oe;
    int            wb, rb, eb;
    a  = cmd[AW-1:0];
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    eb = err_cnt;
    exp_stream = cmd[7] ? 40'h0 : {8'h00, model_bank[a]};
    spi_xfer(cmd, {data, 32'h0}, 40, 1'b0, cap, oe);
    repeat (5) @(negedge clk);
    if (cmd[7]) begin
      check({tag, " wr_cnt"}, 72'(wr_addr_q.size() - wb), 72'(1));
      check({tag, " wr_addr"}, 72'(wr_addr_at(wb)), 72'(a));
      check({tag, " wr_data"}, 72'(wr_data_at(wb)), 72'(data));
      check({tag, " rd_cnt"}, 72'(rd_addr_q.size() - rb), 72'(0));
      model_bank[a] = data;
    end else begin
      check({tag, " rd_cnt"}, 72'(rd_addr_q.size() - rb), 72'(1));
      check({tag, " rd_addr"}, 72'(rd_addr_at(rb)), 72'(a));
      check({tag, " wr_cnt"}, 72'(wr_addr_q.size() - wb), 72'(0));
    end
    check({tag, " miso"}, 72'(cap[39:0]), 72'(exp_stream));
    check({tag, " frame_err"}, 72'(err_cnt - eb), 72'(0));
  endtask

  typedef struct {
    logic [7:0]    cmd;
    logic [DW-1:0] wdata;
    logic          do_preset;
    logic [DW-1:0] preset;
    int            exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int            exp_rd;
    logic [DW-1:0] exp_miso;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] cap;
    logic        oe;
    logic        busy_seen;
    int          wb, rb, eb;
    logic [DW-1:0] w1, w2;

    vecs[0] = '{8'h85, 32'hDEADBEEF, 1'b0, 32'h0,         1, 4'd5,  32'hDEADBEEF, 0, 32'h0};
    vecs[1] = '{8'h03, 32'h0,        1'b1, 32'hA5A50F0F,  0, 4'd3,  32'h0,        1, 32'hA5A50F0F};
    vecs[2] = '{8'hF0, 32'h00000001, 1'b0, 32'h0,         1, 4'd0,  32'h00000001, 0, 32'h0};
    vecs[3] = '{8'h8F, 32'h80000000, 1'b0, 32'h0,         1, 4'd15, 32'h80000000, 0, 32'h0};
    vecs[4] = '{8'h7C, 32'h0,        1'b1, 32'h12345678,  0, 4'd12, 32'h0,        1, 32'h12345678};
    vecs[5] = '{8'h05, 32'hFFFFFFFF, 1'b0, 32'h0,         0, 4'd5,  32'h0,        1, 32'hDEADBEEF};
    vecs[6] = '{8'h82, 32'hFFFFFFFF, 1'b0, 32'h0,         1, 4'd2,  32'hFFFFFFFF, 0, 32'h0};

    reset_n = 1'b0;
    cs_n    = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;

    for (int i = 0; i < NR; i++) begin
      model_bank[i] = $urandom;
      preset(AW'(i), model_bank[i]);
    end
    @(posedge clk); #1;
    check("reset outputs",
          72'({miso, miso_oe, spi_wr_en, spi_addr_wr, data_wr_spi, spi_rd_en, spi_addr_rd, busy, frame_err}),
          72'(0));
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle busy", 72'(busy), 72'(0));

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_preset) begin
        preset(vecs[i].exp_addr, vecs[i].preset);
        model_bank[vecs[i].exp_addr] = vecs[i].preset;
      end
      wb = wr_addr_q.size();
      rb = rd_addr_q.size();
      eb = err_cnt;
      spi_xfer(vecs[i].cmd, {vecs[i].wdata, 32'h0}, 40, 1'b0, cap, oe);
      repeat (5) @(negedge clk);
      check($sformatf("vec%0d wr_cnt", i), 72'(wr_addr_q.size() - wb), 72'(vecs[i].exp_wr));
      if (vecs[i].exp_wr > 0) begin
        check($sformatf("vec%0d wr_addr", i), 72'(wr_addr_at(wb)), 72'(vecs[i].exp_addr));
        check($sformatf("vec%0d wr_data", i), 72'(wr_data_at(wb)), 72'(vecs[i].exp_wdata));
        model_bank[vecs[i].exp_addr] = vecs[i].exp_wdata;
      end
      check($sformatf("vec%0d rd_cnt", i), 72'(rd_addr_q.size() - rb), 72'(vecs[i].exp_rd));
      if (vecs[i].exp_rd > 0)
        check($sformatf("vec%0d rd_addr", i), 72'(rd_addr_at(rb)), 72'(vecs[i].exp_addr));
      check($sformatf("vec%0d miso", i), 72'(cap[39:0]),
            (vecs[i].exp_rd > 0) ? 72'({8'h00, vecs[i].exp_miso}) : 72'(0));
      check($sformatf("vec%0d miso_oe", i), 72'(oe), 72'(1));
      check($sformatf("vec%0d frame_err", i), 72'(err_cnt - eb), 72'(0));
    end

    // Aborted write: cs_n rises after 20 data bits
    wb = wr_addr_q.size();
    eb = err_cnt;
    spi_xfer(8'h81, {32'h13572468, 32'h0}, 28, 1'b1, cap, oe);
    @(posedge clk); #1;
    cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort busy", 72'(busy), 72'(0));
    repeat (10) @(negedge clk);
    check("abort wr_cnt", 72'(wr_addr_q.size() - wb), 72'(0));
    check("abort frame_err", 72'(err_cnt - eb), 72'(1));

    // Reset pulsed during the data phase, cs_n held low across release
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    eb = err_cnt;
    spi_xfer(8'h84, {32'h0F0F0F0F, 32'h0}, 20, 1'b1, cap, oe);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset outputs",
          72'({miso, miso_oe, spi_wr_en, spi_addr_wr, data_wr_spi, spi_rd_en, spi_addr_rd, busy, frame_err}),
          72'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mosi = 1'b1;
      #50;
      sclk = 1'b1;
      busy_seen = busy_seen | busy;
      #50;
      sclk = 1'b0;
      busy_seen = busy_seen | busy;
    end
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postreset idle", 72'(busy_seen), 72'(0));
    check("postreset strobes", 72'((wr_addr_q.size() - wb) + (rd_addr_q.size() - rb)), 72'(0));
    check("postreset frame_err", 72'(err_cnt - eb), 72'(0));
    do_frame_model(8'h82, 32'hCAFEF00D, "postreset wr");
    do_frame_model(8'h02, 32'h0, "postreset rd");

    // Randomized frames against the reference model
    for (int k = 0; k < 24; k++)
      do_frame_model(8'($urandom_range(0, 255)), $urandom, $sformatf("rand%0d", k));

    // Two-word write starting at the last address
    w1 = $urandom;
    w2 = $urandom;
    wb = wr_addr_q.size();
    eb = err_cnt;
    spi_xfer(8'h8F, {w1, w2}, 72, 1'b0, cap, oe);
    repeat (5) @(negedge clk);
`ifdef SPI_AUTO_INC_EN
    check("burst wr_cnt", 72'(wr_addr_q.size() - wb), 72'(2));
    check("burst wr_addr1", 72'(wr_addr_at(wb + 1)), 72'(0));
    check("burst wr_data1", 72'(wr_data_at(wb + 1)), 72'(w2));
`else
    check("burst wr_cnt", 72'(wr_addr_q.size() - wb), 72'(1));
`endif
    check("burst wr_addr0", 72'(wr_addr_at(wb)), 72'(15));
    check("burst wr_data0", 72'(wr_data_at(wb)), 72'(w1));
    check("burst miso", cap, 72'(0));
    check("burst frame_err", 72'(err_cnt - eb), 72'(0));

    check("wr_rd overlap", 72'(both_seen), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_access.md
SPI_REG_ACCESS -- requirements
Module: spi_reg_access

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register word width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16: register count; ADDR_W = $clog2(NUM_REGS), max 7.
REQ-003 SHALL have ports:
  clk  in  1  system clock;
  reset_n  in  1  reset, asynchronous, active-low;
  sclk  in  1  SPI clock, mode 0, async to clk;
  cs_n  in  1  SPI chip select, active-low, async;
  mosi  in  1  SPI serial data in, async;
  miso  out  1  SPI serial data out;
  miso_oe  out  1  miso drive enable, high while cs_n synchronized low;
  spi_wr_en  out  1  one-cycle register write strobe;
  spi_addr_wr  out  ADDR_W  write address;
  data_wr_spi  out  DATA_WIDTH  write data;
  spi_rd_en  out  1  one-cycle register read strobe;
  spi_addr_rd  out  ADDR_W  read address;
  data_rd_spi  in  DATA_WIDTH  read data, combinational from register bank, valid in the spi_rd_en cycle;
  busy  out  1  high while a frame is in progress;
  frame_err  out  1  one-cycle pulse on aborted frame.

Function
REQ-004 SHALL pass sclk, cs_n and mosi through 2-FF synchronizers, then 1-FF edge detect; sclk frequency SHALL be at most clk/4.
REQ-005 Frame SHALL be an 8-bit command then DATA_WIDTH data bits, all MSB first; command bit 7 = 1 write / 0 read, bits [ADDR_W-1:0] = address, other bits ignored.
REQ-006 mosi SHALL be sampled on synchronized sclk rising edges; miso SHALL update on synchronized sclk falling edges.
REQ-007 FSM states: IDLE, CMD, RD_LOAD, DATA, HOLD.
REQ-008 Transitions:
  IDLE->CMD on cs_n falling;
  CMD->RD_LOAD after 8th rising edge if read;
  CMD->DATA after 8th rising edge if write;
  RD_LOAD->DATA after 1 cycle;
  DATA->HOLD after DATA_WIDTH rising edges;
  HOLD->IDLE on cs_n rising;
  any state->IDLE on cs_n rising.
REQ-009 Write: on the cycle after the DATA_WIDTH-th rising edge is detected, spi_wr_en SHALL pulse high for exactly 1 clk, with spi_addr_wr and data_wr_spi stable in that cycle.
REQ-010 Read: in RD_LOAD, spi_rd_en SHALL pulse for exactly 1 clk with spi_addr_rd valid; data_rd_spi SHALL be captured into the output shift register in that cycle.
REQ-011 The captured MSB SHALL drive miso immediately; the first falling edge after RD_LOAD SHALL NOT shift; each later falling edge shifts 1 bit.
REQ-012 During write frames and the command phase, miso SHALL be 0.
REQ-013 cs_n rising before a frame completes SHALL produce no spi_wr_en, SHALL pulse frame_err for 1 clk and SHALL return the FSM to IDLE.
REQ-014 In HOLD, extra sclk edges SHALL be ignored (no strobes, miso = 0) unless SPI_AUTO_INC_EN is defined.
REQ-015 busy SHALL be high in all states except IDLE.
REQ-016 spi_wr_en and spi_rd_en SHALL never be high in the same cycle.

Reset
REQ-017 While reset_n is low, all outputs SHALL be 0, the FSM SHALL be IDLE, and the bit counter, shift registers and synchronizers SHALL be 0 (cs_n synchronizer resets to 1).
REQ-018 Deassertion of reset_n mid-frame SHALL leave the block in IDLE until the next cs_n falling edge.

Configuration
REQ-019 With macro SPI_AUTO_INC_EN defined: after each completed data word with cs_n still low, the address SHALL increment (NUM_REGS-1 wraps to 0) and the FSM SHALL re-enter DATA (write) or RD_LOAD (read) for burst transfers.
REQ-020 Without SPI_AUTO_INC_EN: exactly one word per frame; HOLD behaviour per REQ-014.

Structure
REQ-021 Package spi_reg_pkg SHALL hold the FSM state enum, CMD_W = 8 and WR_BIT = 7.
REQ-022 Sub-module spi_sync_edge SHALL implement one 2-FF synchronizer plus rise/fall detect; it is instantiated for sclk and cs_n, and mosi uses its synchronizer only.

Verification
REQ-023 Write frame cmd 0x85, data 0xDEADBEEF -> single spi_wr_en pulse, spi_addr_wr = 5, data_wr_spi = 0xDEADBEEF.
REQ-024 Read frame cmd 0x03 with data_rd_spi = 0xA5A5_0F0F -> single spi_rd_en pulse with spi_addr_rd = 3; miso shifts out 0xA5A50F0F MSB first.
REQ-025 cs_n raised after 20 bits of a write frame -> no spi_wr_en, one frame_err pulse, busy = 0 within 4 clk.
REQ-026 reset_n pulsed low during the data phase -> all outputs 0; the next complete frame to address 2 executes correctly.
REQ-027 With SPI_AUTO_INC_EN: write burst starting at address 15 with 2 words -> writes to 15 then 0; without the macro -> only the write to 15.
